// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris piece cell streamer: piece encodings,
// streamer FSM states and the unrotated cell offset table.
package tetris_pkg;

    typedef enum logic [2:0] {
        PIECE_O = 3'd0,
        PIECE_I = 3'd1,
        PIECE_L = 3'd2,
        PIECE_J = 3'd3,
        PIECE_S = 3'd4,
        PIECE_Z = 3'd5,
        PIECE_T = 3'd6,
        PIECE_X = 3'd7
    } piece_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    typedef struct packed {
        logic signed [2:0] dx;
        logic signed [2:0] dy;
    } offset_t;

    // Rotation-0 offsets indexed [piece type][cell index]; cell 0 is always the anchor.
    // Code 7 has no piece of its own and reuses the I shape.
    localparam offset_t ROT0_OFFSETS [8][4] = '{
        '{'{3'sd0, 3'sd0}, '{ 3'sd0, 3'sd1}, '{ 3'sd1, 3'sd1}, '{ 3'sd1, 3'sd0}},
        '{'{3'sd0, 3'sd0}, '{-3'sd1, 3'sd0}, '{ 3'sd1, 3'sd0}, '{ 3'sd2, 3'sd0}},
        '{'{3'sd0, 3'sd0}, '{-3'sd1, 3'sd0}, '{ 3'sd1, 3'sd0}, '{ 3'sd1, 3'sd1}},
        '{'{3'sd0, 3'sd0}, '{-3'sd1, 3'sd0}, '{ 3'sd1, 3'sd0}, '{-3'sd1, 3'sd1}},
        '{'{3'sd0, 3'sd0}, '{ 3'sd0, 3'sd1}, '{ 3'sd1, 3'sd1}, '{-3'sd1, 3'sd0}},
        '{'{3'sd0, 3'sd0}, '{ 3'sd0, 3'sd1}, '{-3'sd1, 3'sd1}, '{ 3'sd1, 3'sd0}},
        '{'{3'sd0, 3'sd0}, '{ 3'sd0, 3'sd1}, '{-3'sd1, 3'sd0}, '{ 3'sd1, 3'sd0}},
        '{'{3'sd0, 3'sd0}, '{-3'sd1, 3'sd0}, '{ 3'sd1, 3'sd0}, '{ 3'sd2, 3'sd0}}
    };

endpackage

// File: rtl/cell_offset_rom.sv
// Combinational lookup of one cell's (dx,dy) offset for a given piece,
// rotation and cell index. Each rotation step turns the offset 90 degrees CCW.
module cell_offset_rom
    import tetris_pkg::*;
(
    input  logic [2:0]        i_type,
    input  logic [1:0]        i_rot,
    input  logic [1:0]        i_idx,
    output logic signed [2:0] o_dx,
    output logic signed [2:0] o_dy
);

    offset_t    w_base;
    logic [1:0] w_rot;

    assign w_base = ROT0_OFFSETS[i_type][i_idx];

    // The O piece looks the same in every orientation, so its rotation is dropped.
    assign w_rot = (i_type == PIECE_O) ? 2'd0 : i_rot;

    // Apply the CCW turn (dx,dy) -> (-dy,dx) the requested number of times in closed form.
    always_comb begin
        o_dx = w_base.dx;
        o_dy = w_base.dy;
        case (w_rot)
            2'd1: begin
                o_dx = -w_base.dy;
                o_dy = w_base.dx;
            end
            2'd2: begin
                o_dx = -w_base.dx;
                o_dy = -w_base.dy;
            end
            2'd3: begin
                o_dx = w_base.dy;
                o_dy = -w_base.dx;
            end
            default: begin
                o_dx = w_base.dx;
                o_dy = w_base.dy;
            end
        endcase
    end

endmodule

// File: rtl/piece_cell_streamer.sv
// Accepts one tetris piece request and streams its four board cells over a
// valid/ready handshake, flagging cells that fall off the board and reporting
// whether the whole piece fits once the last cell has been taken.
module piece_cell_streamer
    import tetris_pkg::*;
#(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int XW      = 4,
    parameter int YW      = 5
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_type,
    input  logic [1:0]    req_rot,
    input  logic [XW-1:0] req_x,
    input  logic [YW-1:0] req_y,
    output logic          cell_valid,
    input  logic          cell_ready,
    output logic [XW-1:0] cell_x,
    output logic [YW-1:0] cell_y,
    output logic [1:0]    cell_idx,
    output logic          cell_last,
    output logic          cell_oob,
    output logic          done,
    output logic          piece_fits
);

    localparam logic signed [XW+1:0] LIM_X = (XW+2)'(BOARD_W);
    localparam logic signed [YW+1:0] LIM_Y = (YW+2)'(BOARD_H);

    state_e           r_state;
    logic [2:0]       r_type;
    logic [1:0]       r_rot;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [1:0]       r_idx;
    logic             r_cellValid;
    logic [XW-1:0]    r_cellX;
    logic [YW-1:0]    r_cellY;
    logic             r_cellLast;
    logic             r_cellOob;
    logic             r_oobAcc;
    logic             r_done;
    logic             r_pieceFits;

    logic             w_idle;
    logic [2:0]       w_romType;
    logic [1:0]       w_romRot;
    logic [1:0]       w_romIdx;
    logic [XW-1:0]    w_baseX;
    logic [YW-1:0]    w_baseY;
    logic signed [2:0] w_dx;
    logic signed [2:0] w_dy;
    logic signed [XW+1:0] w_sumX;
    logic signed [YW+1:0] w_sumY;
    logic             w_oob;

    // In IDLE the lookup works on the incoming request (cell 0); in EMIT it
    // prepares the cell after the one currently presented.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_romType = w_idle ? req_type : r_type;
    assign w_romRot  = w_idle ? req_rot  : r_rot;
    assign w_romIdx  = w_idle ? 2'd0     : r_idx + 2'd1;
    assign w_baseX   = w_idle ? req_x    : r_x;
    assign w_baseY   = w_idle ? req_y    : r_y;

    cell_offset_rom u_rom (
        .i_type (w_romType),
        .i_rot  (w_romRot),
        .i_idx  (w_romIdx),
        .o_dx   (w_dx),
        .o_dy   (w_dy)
    );

    // Two guard bits keep negative and just-past-the-edge coordinates distinguishable.
    assign w_sumX = $signed({2'b00, w_baseX}) + $signed({{(XW-1){w_dx[2]}}, w_dx});
    assign w_sumY = $signed({2'b00, w_baseY}) + $signed({{(YW-1){w_dy[2]}}, w_dy});
    assign w_oob  = w_sumX[XW+1] | w_sumY[YW+1] | (w_sumX >= LIM_X) | (w_sumY >= LIM_Y);

    // Request capture, cell sequencing and the done/fits report, all registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_type      <= 3'd0;
            r_rot       <= 2'd0;
            r_x         <= '0;
            r_y         <= '0;
            r_idx       <= 2'd0;
            r_cellValid <= 1'b0;
            r_cellX     <= '0;
            r_cellY     <= '0;
            r_cellLast  <= 1'b0;
            r_cellOob   <= 1'b0;
            r_oobAcc    <= 1'b0;
            r_done      <= 1'b0;
            r_pieceFits <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_type      <= req_type;
                        r_rot       <= req_rot;
                        r_x         <= req_x;
                        r_y         <= req_y;
                        r_idx       <= 2'd0;
                        r_cellValid <= 1'b1;
                        r_cellX     <= w_sumX[XW-1:0];
                        r_cellY     <= w_sumY[YW-1:0];
                        r_cellLast  <= 1'b0;
                        r_cellOob   <= w_oob;
                        r_oobAcc    <= 1'b0;
                        r_state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (cell_ready) begin
                        if (r_idx == 2'd3) begin
                            r_cellValid <= 1'b0;
                            r_done      <= 1'b1;
                            r_pieceFits <= ~(r_oobAcc | r_cellOob);
                            r_state     <= ST_IDLE;
                        end else begin
                            r_idx      <= r_idx + 2'd1;
                            r_cellX    <= w_sumX[XW-1:0];
                            r_cellY    <= w_sumY[YW-1:0];
                            r_cellLast <= (r_idx == 2'd2);
                            r_cellOob  <= w_oob;
                            r_oobAcc   <= r_oobAcc | r_cellOob;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = w_idle;
    assign cell_valid = r_cellValid;
    assign cell_x     = r_cellX;
    assign cell_y     = r_cellY;
    assign cell_idx   = r_idx;
    assign cell_last  = r_cellLast;
    assign cell_oob   = r_cellOob;
    assign done       = r_done;
    assign piece_fits = r_pieceFits;

endmodule

// File: tb/tb_piece_cell_streamer.sv
// Directed bench for piece_cell_streamer: hand-computed cell lists for several
// pieces, rotations and board edges, plus backpressure, busy requests and abort.
module tb_piece_cell_streamer;

    logic       clk;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_type;
    logic [1:0] req_rot;
    logic [3:0] req_x;
    logic [4:0] req_y;
    logic       cell_valid;
    logic       cell_ready;
    logic [3:0] cell_x;
    logic [4:0] cell_y;
    logic [1:0] cell_idx;
    logic       cell_last;
    logic       cell_oob;
    logic       done;
    logic       piece_fits;

    int totalCount;
    int badCount;
    int lastFits;
    int expX   [4];
    int expY   [4];
    int expOob [4];

    piece_cell_streamer #(
        .BOARD_W (10),
        .BOARD_H (20),
        .XW      (4),
        .YW      (5)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_type   (req_type),
        .req_rot    (req_rot),
        .req_x      (req_x),
        .req_y      (req_y),
        .cell_valid (cell_valid),
        .cell_ready (cell_ready),
        .cell_x     (cell_x),
        .cell_y     (cell_y),
        .cell_idx   (cell_idx),
        .cell_last  (cell_last),
        .cell_oob   (cell_oob),
        .done       (done),
        .piece_fits (piece_fits)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one request for a single edge; returns at the negedge where cell 0 should show.
    task automatic applyStimulus(input int t, input int r, input int x, input int y);
        @(negedge clk);
        checkOutput("req_ready_before_req", int'(req_ready), 1);
        req_valid = 1'b1;
        req_type  = 3'(t);
        req_rot   = 2'(r);
        req_x     = 4'(x);
        req_y     = 5'(y);
        stepCycle();
        req_valid = 1'b0;
    endtask

    task automatic checkCell(input string tag, input int idx);
        checkOutput({tag, "_valid"}, int'(cell_valid), 1);
        checkOutput({tag, "_idx"},   int'(cell_idx), idx);
        checkOutput({tag, "_x"},     int'(cell_x), expX[idx]);
        checkOutput({tag, "_y"},     int'(cell_y), expY[idx]);
        checkOutput({tag, "_last"},  int'(cell_last), (idx == 3) ? 1 : 0);
        checkOutput({tag, "_oob"},   int'(cell_oob), expOob[idx]);
        checkOutput({tag, "_busy"},  int'(req_ready), 0);
        checkOutput({tag, "_fitsheld"}, int'(piece_fits), lastFits);
    endtask

    task automatic checkDone(input string tag, input int fits);
        checkOutput({tag, "_done"},   int'(done), 1);
        checkOutput({tag, "_fits"},   int'(piece_fits), fits);
        checkOutput({tag, "_vlow"},   int'(cell_valid), 0);
        checkOutput({tag, "_ready"},  int'(req_ready), 1);
        lastFits = fits;
        stepCycle();
        checkOutput({tag, "_donepulse"}, int'(done), 0);
        checkOutput({tag, "_fitshold"},  int'(piece_fits), lastFits);
    endtask

    task automatic runPiece(input string tag, input int t, input int r,
                            input int x, input int y, input int fits);
        applyStimulus(t, r, x, y);
        for (int i = 0; i < 4; i++) begin
            checkCell($sformatf("%s_c%0d", tag, i), i);
            stepCycle();
        end
        checkDone(tag, fits);
    endtask

    initial begin
        totalCount = 0;
        badCount   = 0;
        lastFits   = 0;
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_type   = 3'd0;
        req_rot    = 2'd0;
        req_x      = 4'd0;
        req_y      = 5'd0;
        cell_ready = 1'b1;

        // Reset: everything cleared, ready to accept.
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        stepCycle();
        checkOutput("rst_valid", int'(cell_valid), 0);
        checkOutput("rst_x",     int'(cell_x), 0);
        checkOutput("rst_y",     int'(cell_y), 0);
        checkOutput("rst_idx",   int'(cell_idx), 0);
        checkOutput("rst_last",  int'(cell_last), 0);
        checkOutput("rst_oob",   int'(cell_oob), 0);
        checkOutput("rst_done",  int'(done), 0);
        checkOutput("rst_fits",  int'(piece_fits), 0);
        checkOutput("rst_ready", int'(req_ready), 1);

        // T, rot0 at (4,10): fully on the board.
        expX = '{4, 4, 3, 5};  expY = '{10, 11, 10, 10};  expOob = '{0, 0, 0, 0};
        runPiece("t_r0", 6, 0, 4, 10, 1);

        // I, rot1 at (5,0): second cell lands at y=-1 (low bits 31).
        expX = '{5, 5, 5, 5};  expY = '{0, 31, 1, 2};  expOob = '{0, 1, 0, 0};
        runPiece("i_r1", 1, 1, 5, 0, 0);

        // I, rot0 at (9,5): runs off the right edge.
        expX = '{9, 8, 10, 11};  expY = '{5, 5, 5, 5};  expOob = '{0, 0, 1, 1};
        runPiece("i_r0", 1, 0, 9, 5, 0);

        // O with rot3 must ignore rotation; at (9,19) three cells leave the board.
        expX = '{9, 9, 10, 10};  expY = '{19, 20, 20, 19};  expOob = '{0, 1, 1, 1};
        runPiece("o_r3", 0, 3, 9, 19, 0);

        // L, rot2 at (5,5): half turn, all in bounds.
        expX = '{5, 6, 4, 4};  expY = '{5, 5, 5, 4};  expOob = '{0, 0, 0, 0};
        runPiece("l_r2", 2, 2, 5, 5, 1);

        // S at (4,4) with 3 stalled cycles at idx1 and a busy request raised meanwhile.
        expX = '{4, 4, 5, 3};  expY = '{4, 5, 5, 4};  expOob = '{0, 0, 0, 0};
        applyStimulus(4, 0, 4, 4);
        checkCell("bp_c0", 0);
        stepCycle();
        cell_ready = 1'b0;
        req_valid  = 1'b1;
        req_type   = 3'd6;
        req_rot    = 2'd0;
        req_x      = 4'd1;
        req_y      = 5'd1;
        for (int k = 0; k < 3; k++) begin
            checkCell($sformatf("bp_hold%0d", k), 1);
            stepCycle();
        end
        cell_ready = 1'b1;
        checkCell("bp_c1", 1);
        stepCycle();
        checkCell("bp_c2", 2);
        stepCycle();
        checkCell("bp_c3", 3);
        stepCycle();
        checkOutput("bp_done",  int'(done), 1);
        checkOutput("bp_fits",  int'(piece_fits), 1);
        checkOutput("bp_vlow",  int'(cell_valid), 0);
        checkOutput("bp_ready", int'(req_ready), 1);
        lastFits = 1;
        // The still-pending request is only taken now, after one IDLE cycle.
        stepCycle();
        req_valid = 1'b0;
        expX = '{1, 1, 0, 2};  expY = '{1, 2, 1, 1};  expOob = '{0, 0, 0, 0};
        checkOutput("busy_donepulse", int'(done), 0);
        for (int i = 0; i < 4; i++) begin
            checkCell($sformatf("busy_c%0d", i), i);
            stepCycle();
        end
        checkDone("busy", 1);

        // J at (3,3), reset hits while idx2 is presented: no done, clean restart.
        expX = '{3, 2, 4, 2};  expY = '{3, 3, 3, 4};  expOob = '{0, 0, 0, 0};
        applyStimulus(3, 0, 3, 3);
        checkCell("ab_c0", 0);
        stepCycle();
        checkCell("ab_c1", 1);
        stepCycle();
        checkCell("ab_c2", 2);
        resetn = 1'b0;
        #1;
        checkOutput("ab_valid", int'(cell_valid), 0);
        checkOutput("ab_idx",   int'(cell_idx), 0);
        checkOutput("ab_ready", int'(req_ready), 1);
        checkOutput("ab_fits",  int'(piece_fits), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput($sformatf("ab_nodone%0d", k), int'(done), 0);
        end
        resetn   = 1'b1;
        lastFits = 0;
        for (int k = 0; k < 2; k++) begin
            stepCycle();
            checkOutput($sformatf("ab_post_done%0d", k), int'(done), 0);
            checkOutput($sformatf("ab_post_ready%0d", k), int'(req_ready), 1);
            checkOutput($sformatf("ab_post_valid%0d", k), int'(cell_valid), 0);
        end

        // Normal operation resumes after the abort.
        expX = '{5, 6, 4, 4};  expY = '{5, 5, 5, 4};  expOob = '{0, 0, 0, 0};
        runPiece("after_ab", 2, 2, 5, 5, 1);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

    // Safety net so a broken run still ends with a summary.
    initial begin
        #200000;
        badCount++;
        $display("[TB] FAIL timeout: got running, expected finished");
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/piece_cell_streamer.md
PIECE_CELL_STREAMER -- requirements
Module: piece_cell_streamer

Interface
REQ-001 The block SHALL have parameter BOARD_W, default 10, meaning board columns; in-bounds x is 0..BOARD_W-1.
REQ-002 The block SHALL have parameter BOARD_H, default 20, meaning board rows; in-bounds y is 0..BOARD_H-1.
REQ-003 The block SHALL have parameter XW, default 4, meaning x coordinate width.
REQ-004 The block SHALL have parameter YW, default 5, meaning y coordinate width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port req_valid, input, 1 bit: a piece request is present.
REQ-008 The block SHALL have port req_ready, output, 1 bit: the block accepts a request.
REQ-009 The block SHALL have port req_type, input, 3 bits: O=0, I=1, L=2, J=3, S=4, Z=5, T=6.
REQ-010 The block SHALL have port req_rot, input, 2 bits: rotation count, 90 degrees CCW per step.
REQ-011 The block SHALL have ports req_x (input, XW bits) and req_y (input, YW bits): the anchor cell.
REQ-012 The block SHALL have ports cell_valid (output, 1 bit) and cell_ready (input, 1 bit): the cell handshake.
REQ-013 The block SHALL have ports cell_x (output, XW bits), cell_y (output, YW bits) and cell_idx (output, 2 bits): the cell coordinates and cell number 0..3.
REQ-014 The block SHALL have ports cell_last (output, 1 bit), true when cell_idx=3, and cell_oob (output, 1 bit), true when the current cell is out of bounds.
REQ-015 The block SHALL have ports done (output, 1 bit), a 1-cycle pulse, and piece_fits (output, 1 bit): no cell of the last piece was out of bounds.

Function
REQ-016 The block SHALL use these rotation-0 offsets (dx,dy), listed for idx0..3:
- O: (0,0),(0,1),(1,1),(1,0)
- I: (0,0),(-1,0),(1,0),(2,0)
- L: (0,0),(-1,0),(1,0),(1,1)
- J: (0,0),(-1,0),(1,0),(-1,1)
- S: (0,0),(0,1),(1,1),(-1,0)
- Z: (0,0),(0,1),(-1,1),(1,0)
- T: (0,0),(0,1),(-1,0),(1,0)
- type 7: same as I.
REQ-017 For each rotation step the block SHALL map (dx,dy) to (-dy,dx), applied req_rot times; O ignores req_rot.
REQ-018 The block SHALL compute x+dx and y+dy as signed values of width XW+2 and YW+2; cell_oob=1 if a result is <0 or >=BOARD_W / BOARD_H; cell_x and cell_y carry the low XW / YW bits.
REQ-019 The FSM SHALL have states IDLE and EMIT; req_ready=1 only in IDLE.
REQ-020 In IDLE, when req_valid=1, the block SHALL register type, rot, x and y, set idx=0 and enter EMIT; cell_valid SHALL rise the next cycle (latency 1).
REQ-021 In EMIT with cell_valid=1 and cell_ready=0, all cell_* outputs SHALL hold stable.
REQ-022 In EMIT, on handshake with idx<3, the block SHALL advance idx by 1, and the next cell SHALL appear the following cycle with no bubble.
REQ-023 On handshake with idx=3, the block SHALL return to IDLE; cell_valid=0 next cycle.
REQ-024 In the cycle after the final handshake, done SHALL pulse 1 cycle and piece_fits SHALL equal the NOR of the four cell_oob values; piece_fits SHALL hold until the next done.
REQ-025 While in EMIT, req_valid SHALL be ignored; the minimum gap between consecutive pieces is 1 IDLE cycle.
REQ-026 Registered request fields SHALL NOT change during EMIT, even if req_* inputs change.

Reset
REQ-027 While resetn=0, the block SHALL force state IDLE, and clear idx, cell_valid, cell_x, cell_y, cell_idx, cell_last, cell_oob, done and piece_fits to 0.
REQ-028 Reset asserted mid-EMIT SHALL abort the piece with no done pulse; req_ready=1 from the first clk edge after release.

Structure
REQ-029 Package tetris_pkg SHALL hold the piece type encodings, the state enum and the rotation-0 offset table.
REQ-030 The block SHALL use one combinational sub-module, cell_offset_rom, with inputs type, rot and idx, and outputs signed 3-bit dx and dy.

Verification
REQ-031 Bench SHALL cover reset: hold resetn=0, then release -> all outputs 0 and req_ready=1.
REQ-032 Bench SHALL cover T, rot0, (4,10), cell_ready=1 -> cells (4,10),(4,11),(3,10),(5,10) on consecutive cycles, then done=1 and piece_fits=1.
REQ-033 Bench SHALL cover I, rot1, (5,0) -> cells (5,0),(5,31),(5,1),(5,2); cell_oob=1 at idx1 only; piece_fits=0.
REQ-034 Bench SHALL cover I, rot0, (9,5) -> x values 9,8,10,11; oob at idx2 and idx3; piece_fits=0.
REQ-035 Bench SHALL cover backpressure: cell_ready=0 for 3 cycles at idx1 -> cell_x, cell_y and cell_idx held; stream then resumes with idx2.
REQ-036 Bench SHALL cover abort and busy requests: resetn=0 at idx2 -> no done pulse; a new req_valid during EMIT is ignored and accepted only in IDLE.
